// File: rtl/digcal_pkg.sv
// Shared constants, date record and BCD helpers for the calendar stage.
package digcal_pkg;

  typedef enum logic [2:0] {
    SUN = 3'd0, MON = 3'd1, TUE = 3'd2, WED = 3'd3,
    THU = 3'd4, FRI = 3'd5, SAT = 3'd6
  } weekday_e;

  localparam logic [7:0] RST_DAY  = 8'h01;
  localparam logic [4:0] RST_MON  = 5'h01;
  localparam logic [7:0] RST_YEAR = 8'h00;

  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;
  localparam logic [4:0] BCD_MON_MAX    = 5'h12;
  localparam logic [7:0] BCD_YEAR_MAX   = 8'h99;

  typedef struct packed {
    logic [7:0] day;
    logic [4:0] mon;
    logic [7:0] year;
    logic [2:0] wday;
  } date_t;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9)
      r = {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/digcal_dim.sv
// Days in a BCD month for a BCD two-digit year; dim is 00 for an invalid month.
module digcal_dim #(
  parameter bit YEAR00_LEAP = 1'b1
) (
  input  logic [4:0] mon,
  input  logic [7:0] year,
  output logic [7:0] dim,
  output logic       leap
);

  // Divisible-by-4 test done on the digits: even tens need units 0/4/8, odd tens need 2/6.
  always_comb begin
    leap = 1'b0;
    if (year == 8'h00)
      leap = YEAR00_LEAP;
    else if (!year[4])
      leap = (year[3:0] == 4'd0) || (year[3:0] == 4'd4) || (year[3:0] == 4'd8);
    else
      leap = (year[3:0] == 4'd2) || (year[3:0] == 4'd6);
  end

  always_comb begin
    dim = 8'h00;
    case (mon)
      5'h01, 5'h03, 5'h05, 5'h07,
      5'h08, 5'h10, 5'h12:         dim = 8'h31;
      5'h04, 5'h06, 5'h09, 5'h11:  dim = 8'h30;
      5'h02:                       dim = leap ? 8'h29 : 8'h28;
      default:                     dim = 8'h00;
    endcase
  end

endmodule

// File: rtl/digcal_date.sv
// BCD calendar: advances day/month/year/weekday on the 23:59:59 edge, accepts
// validated date loads and flags rejected ones.
module digcal_date
  import digcal_pkg::*;
#(
  parameter int RST_WEEKDAY = 6,
  parameter bit YEAR00_LEAP = 1'b1
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic [1:0] H1,
  input  logic [3:0] H0,
  input  logic [3:0] M1,
  input  logic [3:0] M0,
  input  logic [3:0] S1,
  input  logic [3:0] S0,
  input  logic       LD_time,
  input  logic       LD_date,
  input  logic [1:0] D_in1,
  input  logic [3:0] D_in0,
  input  logic       Mo_in1,
  input  logic [3:0] Mo_in0,
  input  logic [3:0] Y_in1,
  input  logic [3:0] Y_in0,
  input  logic [2:0] W_in,
  output logic [1:0] D_out1,
  output logic [3:0] D_out0,
  output logic       Mo_out1,
  output logic [3:0] Mo_out0,
  output logic [3:0] Y_out1,
  output logic [3:0] Y_out0,
  output logic [2:0] W_out,
  output logic       new_day,
  output logic       date_err
);

  date_t      cur, adv, ld;
  logic [7:0] cur_dim, ld_dim;
  logic       unused_cur_leap, unused_ld_leap;
  logic       detect, ld_ok;

  digcal_dim #(.YEAR00_LEAP(YEAR00_LEAP)) u_dim_cur (
    .mon  (cur.mon),
    .year (cur.year),
    .dim  (cur_dim),
    .leap (unused_cur_leap)
  );

  digcal_dim #(.YEAR00_LEAP(YEAR00_LEAP)) u_dim_ld (
    .mon  (ld.mon),
    .year (ld.year),
    .dim  (ld_dim),
    .leap (unused_ld_leap)
  );

  always_comb begin
    ld = '{day:  {2'b00, D_in1, D_in0},
           mon:  {Mo_in1, Mo_in0},
           year: {Y_in1, Y_in0},
           wday: W_in};
  end

  assign detect = ({2'b00, H1, H0} == BCD_HOUR_MAX) &&
                  ({M1, M0} == BCD_MINSEC_MAX) &&
                  ({S1, S0} == BCD_MINSEC_MAX);

  // ld_dim is 00 for any bad month code, so the day range test also rejects it.
  assign ld_ok = bcd_ok(D_in0) && bcd_ok(Mo_in0) && bcd_ok(Y_in1) && bcd_ok(Y_in0) &&
                 (ld.day != 8'h00) && (ld.day <= ld_dim) && (W_in <= SAT);

  always_comb begin
    adv      = cur;
    adv.wday = (cur.wday >= 3'(SAT)) ? 3'(SUN) : cur.wday + 3'd1;
    if (cur.day < cur_dim) begin
      adv.day = bcd_inc(cur.day);
    end else begin
      adv.day = RST_DAY;
      if (cur.mon < BCD_MON_MAX) begin
        adv.mon = (cur.mon[3:0] == 4'd9) ? 5'h10 : cur.mon + 5'd1;
      end else begin
        adv.mon  = RST_MON;
        adv.year = (cur.year == BCD_YEAR_MAX) ? 8'h00 : bcd_inc(cur.year);
      end
    end
  end

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      cur      <= '{day: RST_DAY, mon: RST_MON, year: RST_YEAR, wday: 3'(RST_WEEKDAY)};
      new_day  <= 1'b0;
      date_err <= 1'b0;
    end else if (LD_date) begin
      if (ld_ok) begin
        cur      <= ld;
        date_err <= 1'b0;
      end else begin
        date_err <= 1'b1;
      end
      new_day <= 1'b0;
    end else if (detect && !LD_time) begin
      cur     <= adv;
      new_day <= 1'b1;
    end else begin
      new_day <= 1'b0;
    end
  end

  assign {D_out1, D_out0}   = cur.day[5:0];
  assign {Mo_out1, Mo_out0} = cur.mon;
  assign {Y_out1, Y_out0}   = cur.year;
  assign W_out              = cur.wday;

  // day tens never exceeds 3, so the top two bits of cur.day stay zero
  logic unused_day_hi;
  assign unused_day_hi = |cur.day[7:6];

endmodule

// File: tb/tb_digcal_date.sv
// Random and directed stimulus for digcal_date against an integer calendar model.
module tb_digcal_date;

  localparam bit YL = 1'b1;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] H1;
  logic [3:0] H0, M1, M0, S1, S0;
  logic       LD_time, LD_date;
  logic [1:0] D_in1;
  logic [3:0] D_in0;
  logic       Mo_in1;
  logic [3:0] Mo_in0, Y_in1, Y_in0;
  logic [2:0] W_in;
  logic [1:0] D_out1;
  logic [3:0] D_out0;
  logic       Mo_out1;
  logic [3:0] Mo_out0, Y_out1, Y_out0;
  logic [2:0] W_out;
  logic       new_day, date_err;

  digcal_date #(.RST_WEEKDAY(6), .YEAR00_LEAP(YL)) dut (
    .clk_1s(clk_1s), .reset(reset),
    .H1(H1), .H0(H0), .M1(M1), .M0(M0), .S1(S1), .S0(S0),
    .LD_time(LD_time), .LD_date(LD_date),
    .D_in1(D_in1), .D_in0(D_in0), .Mo_in1(Mo_in1), .Mo_in0(Mo_in0),
    .Y_in1(Y_in1), .Y_in0(Y_in0), .W_in(W_in),
    .D_out1(D_out1), .D_out0(D_out0), .Mo_out1(Mo_out1), .Mo_out0(Mo_out0),
    .Y_out1(Y_out1), .Y_out0(Y_out0), .W_out(W_out),
    .new_day(new_day), .date_err(date_err)
  );

  always #5 clk_1s = ~clk_1s;

  int n_chk = 0, n_pass = 0;
  int m_day, m_mon, m_year, m_w;
  bit m_nd, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit is_leap(int y);
    return (y == 0) ? YL : (y % 4 == 0);
  endfunction

  function automatic int dim_of(int mo, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo < 1 || mo > 12) return 0;
    if (mo == 2 && is_leap(y)) return 29;
    return t[mo-1];
  endfunction

  function automatic logic [31:0] bcd(int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    m_day = 1; m_mon = 1; m_year = 0; m_w = 6; m_nd = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int d, mo, y;
    bit ok, midnight;
    midnight = (H1 == 2) && (H0 == 3) && (M1 == 5) && (M0 == 9) && (S1 == 5) && (S0 == 9);
    if (LD_date) begin
      d  = int'(D_in1) * 10 + int'(D_in0);
      mo = int'(Mo_in1) * 10 + int'(Mo_in0);
      y  = int'(Y_in1) * 10 + int'(Y_in0);
      ok = (D_in0 <= 9) && (Mo_in0 <= 9) && (Y_in1 <= 9) && (Y_in0 <= 9) &&
           (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= dim_of(mo, y)) && (W_in <= 6);
      if (ok) begin
        m_day = d; m_mon = mo; m_year = y; m_w = int'(W_in); m_err = 0;
      end else m_err = 1;
      m_nd = 0;
    end else if (midnight && !LD_time) begin
      m_w = (m_w + 1) % 7;
      if (m_day < dim_of(m_mon, m_year)) m_day++;
      else begin
        m_day = 1;
        if (m_mon < 12) m_mon++;
        else begin m_mon = 1; m_year = (m_year + 1) % 100; end
      end
      m_nd = 1;
    end else m_nd = 0;
  endtask

  task automatic check_all();
    chk("day",      {26'd0, D_out1, D_out0}, bcd(m_day));
    chk("mon",      {27'd0, Mo_out1, Mo_out0}, bcd(m_mon));
    chk("year",     {24'd0, Y_out1, Y_out0}, bcd(m_year));
    chk("wday",     {29'd0, W_out}, 32'(m_w));
    chk("new_day",  {31'd0, new_day}, {31'd0, m_nd});
    chk("date_err", {31'd0, date_err}, {31'd0, m_err});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_1s);
    #1;
    check_all();
  endtask

  task automatic set_time(int h, int m, int s);
    H1 = 2'(h / 10); H0 = 4'(h % 10);
    M1 = 4'(m / 10); M0 = 4'(m % 10);
    S1 = 4'(s / 10); S0 = 4'(s % 10);
  endtask

  task automatic set_load(int d, int mo, int y, int w);
    D_in1 = 2'(d / 10);  D_in0 = 4'(d % 10);
    Mo_in1 = 1'(mo / 10); Mo_in0 = 4'(mo % 10);
    Y_in1 = 4'(y / 10);  Y_in0 = 4'(y % 10);
    W_in = 3'(w);
  endtask

  task automatic load(int d, int mo, int y, int w);
    set_load(d, mo, y, w); LD_date = 1; step(); LD_date = 0;
  endtask

  initial begin
    reset = 1; LD_time = 0; LD_date = 0;
    set_time(0, 0, 0); set_load(1, 1, 0, 0);
    model_reset();
    #3 check_all();
    @(negedge clk_1s); reset = 0;

    // leap February
    load(28, 2, 24, 3);
    set_time(23, 59, 59); step();
    chk("leap_feb_day", {26'd0, D_out1, D_out0}, 32'h29);
    chk("leap_feb_nd", {31'd0, new_day}, 32'd1);
    set_time(0, 0, 0); step();
    chk("nd_one_cycle", {31'd0, new_day}, 32'd0);

    // non-leap February
    load(28, 2, 23, 2);
    set_time(23, 59, 59); step();
    chk("nonleap_mon", {27'd0, Mo_out1, Mo_out0}, 32'h03);
    set_time(0, 0, 0);

    // century wrap
    load(31, 12, 99, 5);
    set_time(23, 59, 59); step();
    chk("wrap_year", {24'd0, Y_out1, Y_out0}, 32'h00);
    chk("wrap_wday", {29'd0, W_out}, 32'd6);
    set_time(0, 0, 0);

    // invalid then valid load
    load(31, 4, 25, 1);
    chk("bad_load_err", {31'd0, date_err}, 32'd1);
    load(30, 4, 25, 1);
    chk("good_load_err", {31'd0, date_err}, 32'd0);

    // load collides with midnight, then LD_time suppression
    set_time(23, 59, 59);
    load(10, 6, 25, 2);
    chk("collide_day", {26'd0, D_out1, D_out0}, 32'h10);
    chk("collide_nd", {31'd0, new_day}, 32'd0);
    LD_time = 1; step(); LD_time = 0;
    chk("ldtime_day", {26'd0, D_out1, D_out0}, 32'h10);

    // asynchronous reset with a pending new_day
    step();
    #2 reset = 1; model_reset();
    #1 check_all();
    #2 reset = 0;
    set_time(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50) set_time(23, 59, 59);
      else if (r < 65) begin
        case ($urandom_range(0, 2))
          0: set_time(23, 59, 58);
          1: set_time(22, 59, 59);
          default: set_time(23, 58, 59);
        endcase
      end else begin
        H1 = 2'($urandom); H0 = 4'($urandom); M1 = 4'($urandom);
        M0 = 4'($urandom); S1 = 4'($urandom); S0 = 4'($urandom);
      end
      LD_time = ($urandom_range(0, 9) == 0);
      LD_date = ($urandom_range(0, 7) == 0);
      if (LD_date) begin
        if ($urandom_range(0, 3) == 0) begin
          D_in1 = 2'($urandom); D_in0 = 4'($urandom); Mo_in1 = 1'($urandom);
          Mo_in0 = 4'($urandom); Y_in1 = 4'($urandom); Y_in0 = 4'($urandom);
          W_in = 3'($urandom);
        end else begin
          set_load(($urandom_range(0, 1) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 13)), int'($urandom_range(0, 99)),
                   int'($urandom_range(0, 7)));
        end
      end
      step();
    end
    LD_date = 0; LD_time = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
